// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset PC and the fetch queue entry.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side buses: instruction memory read port and the decode handshake.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_pc;
    logic [WORD_W-1:0] out_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output out_valid, out_instr, out_pc, out_pc_plus4,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  out_valid, out_instr, out_pc, out_pc_plus4,
        output out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch_entry_t with flush; storage resets to zero so the
// head reads as pc 0 / instr 0 out of reset.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    fetch_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]     head_ptr;
    logic [PTR_W-1:0]     tail_ptr;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = entries[head_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                entries[tail_ptr] <= push_data;
                tail_ptr          <= ptr_inc(tail_ptr);
            end
            if (do_pop) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads, buffers responses and
// handles redirects with an epoch tag so stale responses are discarded.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_unit_if.master       fetch_bus,
    input  logic               redirect,
    input  logic [WORD_W-1:0]  redirect_target,
    output logic               fetch_fault
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] inflight_pc;
    logic              inflight;
    logic              inflight_epoch;
    logic              epoch;
    logic              fault;

    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      q_head;
    fetch_entry_t      resp_entry;
    logic              accept;
    logic              resp_push;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    assign accept = fetch_bus.out_valid && fetch_bus.out_ready;

    // A head being accepted this cycle frees its slot, which keeps a 2-deep
    // queue streaming one instruction per cycle without overflowing.
    assign occupancy = {1'b0, q_count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, accept};

    assign issue = reset_n && !fault && !redirect && (occupancy < (CNT_W+1)'(DEPTH));

    assign resp_push  = inflight && (inflight_epoch == epoch) && !redirect && !fault;
    assign resp_entry = '{instr: fetch_bus.imem_rdata, pc: inflight_pc};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (resp_push),
        .push_data (resp_entry),
        .pop       (accept),
        .flush     (redirect || fault),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc       <= RESET_PC;
            inflight_pc    <= '0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            fault          <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fetch_pc;
                inflight_epoch <= epoch;
                fetch_pc       <= fetch_pc + 32'd4;
            end
            if (redirect && !fault) begin
                epoch    <= ~epoch;
                fetch_pc <= {redirect_target[WORD_W-1:2], 2'b00};
                if (redirect_target[1:0] != 2'b00) begin
                    fault <= 1'b1;
                end
            end
        end
    end

    assign fetch_bus.imem_req     = issue;
    assign fetch_bus.imem_addr    = fetch_pc;
    assign fetch_bus.out_valid    = !q_empty && !fault;
    assign fetch_bus.out_instr    = q_head.instr;
    assign fetch_bus.out_pc       = q_head.pc;
    assign fetch_bus.out_pc_plus4 = q_head.pc + 32'd4;
    assign fetch_fault            = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetches are queued by the stimulus
// and a negedge monitor checks each accepted instruction against them.
module tb_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    fetch_unit_if bus_if ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_bus       (bus_if),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            32'h0000_0008: return 32'h0000_0033;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Synchronous instruction memory: data one cycle after the request.
    always @(posedge clk) begin
        if (bus_if.imem_req) bus_if.imem_rdata <= mem_word(bus_if.imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input logic ready);
        reset_n = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        bus_if.out_ready = ready;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected no fetch", bus_if.out_pc, bus_if.out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", bus_if.out_pc, e.pc);
                chk("sb_instr", bus_if.out_instr, e.instr);
                chk("sb_pc_plus4", bus_if.out_pc_plus4, e.pc + 32'd4);
            end
        end
        if (reset_n && dut.inflight && dut.q_count == 2) begin
            checks++;
            errors++;
            $display("FAIL queue_overflow: got count %0d with response in flight expected below 2", dut.q_count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and first fetches.
        reset_n = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_imem_req", bus_if.imem_req, 0);
        chk("rst_imem_addr", bus_if.imem_addr, 32'h0);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_out_instr", bus_if.out_instr, 32'h0);
        chk("rst_out_pc", bus_if.out_pc, 32'h0);
        chk("rst_out_pc_plus4", bus_if.out_pc_plus4, 32'h4);
        chk("rst_fetch_fault", fetch_fault, 0);
        expect_fetch(32'h0, 32'h11);
        expect_fetch(32'h4, 32'h22);
        expect_fetch(32'h8, 32'h33);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("p1_c0_req", bus_if.imem_req, 1);
        chk("p1_c0_addr", bus_if.imem_addr, 32'h0);
        tick();
        @(negedge clk);
        chk("p1_c1_valid", bus_if.out_valid, 0);
        chk("p1_c1_addr", bus_if.imem_addr, 32'h4);
        tick();
        @(negedge clk);
        chk("p1_c2_valid", bus_if.out_valid, 1);
        chk("p1_c2_pc", bus_if.out_pc, 32'h0);
        chk("p1_c2_plus4", bus_if.out_pc_plus4, 32'h4);
        tick();
        @(negedge clk);
        chk("p1_c3_pc", bus_if.out_pc, 32'h4);
        chk("p1_c3_plus4", bus_if.out_pc_plus4, 32'h8);
        tick();
        @(negedge clk);
        chk("p1_c4_pc", bus_if.out_pc, 32'h8);
        chk("p1_c4_plus4", bus_if.out_pc_plus4, 32'hC);
        tick();
        bus_if.out_ready = 1'b0;

        // Back-pressure: decode stalls for 5 cycles then resumes.
        expect_fetch(32'h0, 32'h11);
        expect_fetch(32'h4, 32'h22);
        expect_fetch(32'h8, 32'h33);
        expect_fetch(32'hC, 32'hA5A5_000C);
        start_phase(1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("p2_c2_req", bus_if.imem_req, 0);
        tick();
        tick();
        @(negedge clk);
        chk("p2_stall_valid", bus_if.out_valid, 1);
        chk("p2_stall_pc", bus_if.out_pc, 32'h0);
        chk("p2_stall_instr", bus_if.out_instr, 32'h11);
        chk("p2_stall_req", bus_if.imem_req, 0);
        chk("p2_stall_count", 32'(dut.q_count), 32'd2);
        tick();
        bus_if.out_ready = 1'b1;
        repeat (3) tick();
        tick();
        bus_if.out_ready = 1'b0;

        // Redirect to 0x40 while pc 4 is the head and pc 8 is in flight.
        expect_fetch(32'h0, 32'h11);
        expect_fetch(32'h4, 32'h22);
        expect_fetch(32'h40, 32'hA5A5_0040);
        start_phase(1'b1);
        tick();
        tick();
        tick();
        redirect = 1'b1;
        redirect_target = 32'h40;
        @(negedge clk);
        chk("p3_redir_req", bus_if.imem_req, 0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("p3_c4_req", bus_if.imem_req, 1);
        chk("p3_c4_addr", bus_if.imem_addr, 32'h40);
        chk("p3_c4_valid", bus_if.out_valid, 0);
        tick();
        @(negedge clk);
        chk("p3_c5_valid", bus_if.out_valid, 0);
        chk("p3_c5_addr", bus_if.imem_addr, 32'h44);
        tick();
        @(negedge clk);
        chk("p3_c6_valid", bus_if.out_valid, 1);
        chk("p3_c6_pc", bus_if.out_pc, 32'h40);
        tick();
        bus_if.out_ready = 1'b0;

        // Misaligned redirect: sticky fault until reset.
        expect_fetch(32'h0, 32'h11);
        expect_fetch(32'h4, 32'h22);
        start_phase(1'b1);
        tick();
        tick();
        tick();
        redirect = 1'b1;
        redirect_target = 32'h42;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("p4_fault", fetch_fault, 1);
            chk("p4_req", bus_if.imem_req, 0);
            chk("p4_valid", bus_if.out_valid, 0);
            tick();
        end
        chk("p4_addr_aligned", bus_if.imem_addr, 32'h40);
        reset_n = 1'b0;
        #1;
        chk("p4_reset_clears_fault", fetch_fault, 0);

        // Redirect to the last word: PC wraps to 0.
        expect_fetch(32'h0, 32'h11);
        expect_fetch(32'h4, 32'h22);
        expect_fetch(32'hFFFF_FFFC, 32'h5A5A_FFFC);
        expect_fetch(32'h0, 32'h11);
        start_phase(1'b1);
        tick();
        tick();
        tick();
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("p5_c6_pc", bus_if.out_pc, 32'hFFFF_FFFC);
        chk("p5_c6_plus4", bus_if.out_pc_plus4, 32'h0);
        tick();
        @(negedge clk);
        chk("p5_c7_pc", bus_if.out_pc, 32'h0);
        chk("p5_c7_plus4", bus_if.out_pc_plus4, 32'h4);
        tick();
        bus_if.out_ready = 1'b0;

        // Asynchronous reset mid-stream, then restart from the reset PC.
        expect_fetch(32'h0, 32'h11);
        expect_fetch(32'h4, 32'h22);
        start_phase(1'b1);
        tick();
        tick();
        tick();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("p6_async_valid", bus_if.out_valid, 0);
        chk("p6_async_req", bus_if.imem_req, 0);
        expect_fetch(32'h0, 32'h11);
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("p6_restart_req", bus_if.imem_req, 1);
        chk("p6_restart_addr", bus_if.imem_addr, 32'h0);
        tick();
        tick();
        @(negedge clk);
        chk("p6_restart_valid", bus_if.out_valid, 1);
        chk("p6_restart_pc", bus_if.out_pc, 32'h0);
        tick();
        bus_if.out_ready = 1'b0;
        repeat (3) tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
